// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: packet-granular round-robin arbiter that shares one FIFO
// write port among NREQ requesters. It runs in the FIFO write-clock domain.
// A grant is held until the owner's last beat is written. A new packet may
// start only when the FIFO has at least MIN_FREE free slots.
//
// Ports:
//   clk           write clock, the same clock as the FIFO wrclk
//   reset         synchronous reset, active high
//   req_valid     per-requester beat valid
//   req_data      requester i data in bits [i*WIDTH +: WIDTH]
//   req_last      the beat is the final beat of its packet
//   req_ready     a beat is accepted when valid and ready are both high
//   fifo_wren     FIFO write enable
//   fifo_datain   FIFO write data
//   fifo_wrfull   FIFO full flag
//   fifo_wrusedw  FIFO fill level (PTR+1 bits)
//   grant         one-hot current owner; all zero when idle
//   pkt_done      one-cycle pulse when a last beat is written
//   pkt_src       requester index for pkt_done; holds between pulses
module fifo_wr_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int PTR      = 4,
  parameter int MIN_FREE = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         req_ready,
  output logic                    fifo_wren,
  output logic [WIDTH-1:0]        fifo_datain,
  input  logic                    fifo_wrfull,
  input  logic [PTR:0]            fifo_wrusedw,
  output logic [NREQ-1:0]         grant,
  output logic                    pkt_done,
  output logic [$clog2(NREQ)-1:0] pkt_src
);

  localparam int IDXW = $clog2(NREQ);

  typedef enum logic {IDLE, XFER} state_t;

  state_t          r_state, w_state_nxt;
  logic [NREQ-1:0] r_grant, w_grant_nxt;
  logic [IDXW-1:0] r_rr_ptr, w_rr_nxt;
  logic [IDXW-1:0] r_pkt_src, w_src_nxt;
  logic            r_pkt_done, w_done_nxt;
  logic [IDXW-1:0] w_gidx;
  logic [IDXW-1:0] w_win_idx;
  logic            w_win_found;
  logic [PTR+1:0]  w_free;
  logic            w_space_ok;
  logic            w_accept;

  // A fill level above DEPTH would wrap the subtraction, so clamp free to 0.
  always_comb begin
    if ({1'b0, fifo_wrusedw} > (PTR+2)'(DEPTH)) w_free = '0;
    else                                         w_free = (PTR+2)'(DEPTH) - {1'b0, fifo_wrusedw};
  end

  assign w_space_ok = (w_free >= (PTR+2)'(MIN_FREE));

  // Encode the one-hot grant as an index for the muxes.
  always_comb begin
    w_gidx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (r_grant[IDXW'(i)]) w_gidx = IDXW'(i);
    end
  end

  // Find the first valid requester, starting at rr_ptr and wrapping at NREQ.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    w_win_found = 1'b0;
    w_win_idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = r_rr_ptr + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_win_found && req_valid[IDXW'(idx)]) begin
        w_win_found = 1'b1;
        w_win_idx   = IDXW'(idx);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_rr_nxt    = r_rr_ptr;
    w_src_nxt   = r_pkt_src;
    w_done_nxt  = 1'b0;
    w_accept    = 1'b0;
    req_ready   = '0;
    fifo_wren   = 1'b0;
    fifo_datain = req_data[w_gidx*WIDTH +: WIDTH];

    case (r_state)
      IDLE: begin
        if (w_win_found && w_space_ok) begin
          w_grant_nxt = NREQ'(1) << w_win_idx;
          w_state_nxt = XFER;
        end
      end
      XFER: begin
        req_ready[w_gidx] = !fifo_wrfull;
        w_accept          = req_valid[w_gidx] & !fifo_wrfull;
        fifo_wren         = w_accept;
        if (w_accept && req_last[w_gidx]) begin
          w_done_nxt  = 1'b1;
          w_src_nxt   = w_gidx;
          w_rr_nxt    = (w_gidx == IDXW'(NREQ-1)) ? '0 : w_gidx + 1'b1;
          w_grant_nxt = '0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Gate the write side at once so a reset mid-packet writes no further beat.
    if (reset) begin
      req_ready   = '0;
      fifo_wren   = 1'b0;
      fifo_datain = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_pkt_done <= 1'b0;
      r_pkt_src  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_pkt_done <= w_done_nxt;
      r_pkt_src  <= w_src_nxt;
    end
  end

  assign grant    = r_grant;
  assign pkt_done = r_pkt_done;
  assign pkt_src  = r_pkt_src;

endmodule
